// File: rtl/card_digit_decoder.sv
// card_digit_decoder
// Reassembles groups of four 5-bit display digit codes (rank1, rank2, suit1,
// suit2) into a card index 0-51 (suit*13 + rank). Illegal groups still
// complete the handshake and are reported with card_err=1 / card_out=63.
// A partial group idle for TIMEOUT cycles is dropped with a one-cycle abort.
module card_digit_decoder #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] dig_in,
  input  logic       dig_valid,
  output logic       dig_ready,
  output logic [5:0] card_out,
  output logic       card_err,
  output logic       card_valid,
  input  logic       card_ready,
  output logic       abort
);

  // State encoding: S_D1..S_D4 wait for digit n of the group, S_OUT holds a result.
  localparam logic [2:0] S_D1  = 3'd0;
  localparam logic [2:0] S_D2  = 3'd1;
  localparam logic [2:0] S_D3  = 3'd2;
  localparam logic [2:0] S_D4  = 3'd3;
  localparam logic [2:0] S_OUT = 3'd4;

  // Idle counter wide enough to hold TIMEOUT; fires when it would reach TIMEOUT.
  localparam int         CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam bit         TO_EN   = (TIMEOUT != 0);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [4:0]    dig_q [3];
  logic [5:0]    card_out_q;
  logic          card_err_q;
  logic          abort_q;

  logic          accept;
  logic          in_group;
  logic          timeout_hit;

  logic [3:0]    rank;
  logic          rank_ok;
  logic [1:0]    suit;
  logic          suit_ok;
  logic [5:0]    dec_card;
  logic          dec_err;

  assign accept      = dig_valid && dig_ready;
  assign in_group    = (state_q == S_D2) || (state_q == S_D3) || (state_q == S_D4);
  // An acceptance in the same cycle wins over the timeout.
  assign timeout_hit = TO_EN && in_group && !accept && (idle_cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_D1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance one digit per acceptance, fall back to S_D1 on timeout
  // or once the consumer has taken the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_D1: begin
        if (accept) state_d = S_D2;
      end
      S_D2: begin
        if (accept)           state_d = S_D3;
        else if (timeout_hit) state_d = S_D1;
      end
      S_D3: begin
        if (accept)           state_d = S_D4;
        else if (timeout_hit) state_d = S_D1;
      end
      S_D4: begin
        if (accept)           state_d = S_OUT;
        else if (timeout_hit) state_d = S_D1;
      end
      S_OUT: begin
        if (card_ready) state_d = S_D1;
      end
      default: state_d = S_D1;
    endcase
  end

  // Outputs driven from state and the result/abort registers.
  always_comb begin
    dig_ready  = (state_q != S_OUT);
    card_valid = (state_q == S_OUT);
    card_out   = card_out_q;
    card_err   = card_err_q;
    abort      = abort_q;
  end

  // Idle counter next value: counts only while a partial group is pending.
  always_comb begin
    idle_cnt_d = '0;
    if (TO_EN && in_group && !accept && !timeout_hit) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Digit slots 0..2 capture digits 1..3; digit 4 is decoded straight from dig_in.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dig
    localparam logic [2:0] SLOT_STATE = 3'(gi);
    // Capture the digit that arrives while waiting for this slot.
    always_ff @(posedge clk) begin
      if (rst) begin
        dig_q[gi] <= '0;
      end else if (accept && (state_q == SLOT_STATE)) begin
        dig_q[gi] <= dig_in;
      end
    end
  end

  // Rank pair decode (first two digits).
  always_comb begin
    rank    = 4'd0;
    rank_ok = 1'b0;
    if (dig_q[1] == 5'd24) begin
      if (dig_q[0] == 5'd13) begin
        rank    = 4'd0;
        rank_ok = 1'b1;
      end else if ((dig_q[0] >= 5'd2) && (dig_q[0] <= 5'd9)) begin
        rank    = 4'(dig_q[0] - 5'd1);
        rank_ok = 1'b1;
      end else if (dig_q[0] == 5'd10) begin
        rank    = 4'd10;
        rank_ok = 1'b1;
      end
    end else if ((dig_q[0] == 5'd1) && (dig_q[1] == 5'd0)) begin
      rank    = 4'd9;
      rank_ok = 1'b1;
    end else if ((dig_q[0] == 5'd0) && (dig_q[1] == 5'd22)) begin
      rank    = 4'd11;
      rank_ok = 1'b1;
    end else if ((dig_q[0] == 5'd12) && (dig_q[1] == 5'd23)) begin
      rank    = 4'd12;
      rank_ok = 1'b1;
    end
  end

  // Suit pair decode (stored third digit plus the live fourth digit).
  always_comb begin
    suit    = 2'd0;
    suit_ok = 1'b0;
    case ({dig_q[2], dig_in})
      {5'd0,  5'd15}: begin suit = 2'd0; suit_ok = 1'b1; end
      {5'd16, 5'd17}: begin suit = 2'd1; suit_ok = 1'b1; end
      {5'd18, 5'd1 }: begin suit = 2'd2; suit_ok = 1'b1; end
      {5'd20, 5'd21}: begin suit = 2'd3; suit_ok = 1'b1; end
      default:        begin suit = 2'd0; suit_ok = 1'b0; end
    endcase
  end

  // Card index: suit*13 + rank fits in 6 bits (max 51); illegal groups map to 63.
  always_comb begin
    dec_err  = !(rank_ok && suit_ok);
    dec_card = 6'd63;
    if (!dec_err) begin
      dec_card = 6'(({4'd0, suit} * 6'd13) + {2'd0, rank});
    end
  end

  // Result registers: loaded on the fourth acceptance, held through S_OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      card_out_q <= '0;
      card_err_q <= 1'b0;
    end else if (accept && (state_q == S_D4)) begin
      card_out_q <= dec_card;
      card_err_q <= dec_err;
    end
  end

  // Abort pulse: high for exactly the cycle after a timeout drops a group.
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_card_digit_decoder.sv
// Directed testbench for card_digit_decoder (instance built with TIMEOUT=8).
module tb_card_digit_decoder;

  logic       clk;
  logic       rst;
  logic [4:0] dig_in;
  logic       dig_valid;
  logic       dig_ready;
  logic [5:0] card_out;
  logic       card_err;
  logic       card_valid;
  logic       card_ready;
  logic       abort;

  int n_cmp;
  int n_err;

  card_digit_decoder #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .dig_in    (dig_in),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .card_out  (card_out),
    .card_err  (card_err),
    .card_valid(card_valid),
    .card_ready(card_ready),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %s: observed %0d expected %0d", tag, obs, exp);
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one digit per cycle with valid held high; returns sampled #1 after the edge.
  task automatic send_digits(input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [4:0] d, input int n);
    logic [4:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int k = 0; k < n; k++) begin
      dig_in    = v[k];
      dig_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    dig_valid = 1'b0;
    dig_in    = 5'd0;
  endtask

  // Check a held result, then release it and confirm the handoff.
  task automatic take_result(input string tag, input logic [5:0] exp_card, input logic exp_err);
    chk({tag, "_valid"}, {31'd0, card_valid}, 32'd1);
    chk({tag, "_card"},  {26'd0, card_out},   {26'd0, exp_card});
    chk({tag, "_err"},   {31'd0, card_err},   {31'd0, exp_err});
    card_ready = 1'b1;
    @(posedge clk);
    #1;
    card_ready = 1'b0;
    chk({tag, "_released"}, {31'd0, card_valid}, 32'd0);
    chk({tag, "_ready"},    {31'd0, dig_ready},  32'd1);
  endtask

  initial begin
    int ab_cnt;
    int ab_early;
    logic [5:0] held;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    dig_in     = 5'd0;
    dig_valid  = 1'b0;
    card_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, card_valid}, 32'd0);
    chk("rst_card",  {26'd0, card_out},   32'd0);
    chk("rst_err",   {31'd0, card_err},   32'd0);
    chk("rst_abort", {31'd0, abort},      32'd0);
    chk("rst_ready", {31'd0, dig_ready},  32'd1);

    // 1: Ace of diamonds, latency one cycle after the fourth acceptance
    send_digits(5'd13, 5'd24, 5'd0, 5'd15, 3);
    chk("t1_not_yet", {31'd0, card_valid}, 32'd0);
    send_digits(5'd15, 5'd0, 5'd0, 5'd0, 1);
    chk("t1_out_ready", {31'd0, dig_ready}, 32'd0);
    take_result("t1", 6'd0, 1'b0);

    // 2: three legal groups back to back
    send_digits(5'd12, 5'd23, 5'd20, 5'd21, 4);
    take_result("t2_ks", 6'd51, 1'b0);
    send_digits(5'd1, 5'd0, 5'd16, 5'd17, 4);
    take_result("t2_10h", 6'd22, 1'b0);
    send_digits(5'd0, 5'd22, 5'd18, 5'd1, 4);
    take_result("t2_qc", 6'd37, 1'b0);

    // 3: illegal group then resync
    send_digits(5'd7, 5'd7, 5'd0, 5'd15, 4);
    take_result("t3_bad", 6'd63, 1'b1);
    send_digits(5'd2, 5'd24, 5'd0, 5'd15, 4);
    take_result("t3_2d", 6'd1, 1'b0);

    // 4: consumer stalls for 10 cycles while digits are offered
    send_digits(5'd10, 5'd24, 5'd20, 5'd21, 4);
    held = card_out;
    chk("t4_js", {26'd0, held}, 32'd49);
    dig_in    = 5'd13;
    dig_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t4_hold%0d_valid", k), {31'd0, card_valid}, 32'd1);
      chk($sformatf("t4_hold%0d_card", k),  {26'd0, card_out},   {26'd0, held});
      chk($sformatf("t4_hold%0d_ready", k), {31'd0, dig_ready},  32'd0);
    end
    dig_valid = 1'b0;
    take_result("t4_js", 6'd49, 1'b0);
    // A clean group afterwards proves no stray digit was latched during the stall
    send_digits(5'd3, 5'd24, 5'd16, 5'd17, 4);
    take_result("t4_after", 6'd15, 1'b0);

    // 5: timeout after two digits, then a fresh group
    send_digits(5'd4, 5'd24, 5'd0, 5'd0, 2);
    ab_cnt   = 0;
    ab_early = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (abort) begin
        ab_cnt++;
        if (k < 7) ab_early++;
      end
    end
    chk("t5_abort_count", ab_cnt,   32'd1);
    chk("t5_abort_early", ab_early, 32'd0);
    chk("t5_valid", {31'd0, card_valid}, 32'd0);
    chk("t5_ready", {31'd0, dig_ready},  32'd1);
    send_digits(5'd9, 5'd24, 5'd18, 5'd1, 4);
    take_result("t5_9c", 6'd34, 1'b0);

    // 6: reset mid-group
    send_digits(5'd6, 5'd24, 5'd20, 5'd0, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_valid", {31'd0, card_valid}, 32'd0);
    chk("t6_card",  {26'd0, card_out},   32'd0);
    chk("t6_err",   {31'd0, card_err},   32'd0);
    chk("t6_abort", {31'd0, abort},      32'd0);
    chk("t6_ready", {31'd0, dig_ready},  32'd1);
    send_digits(5'd5, 5'd24, 5'd16, 5'd17, 4);
    take_result("t6_5h", 6'd17, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
